// File: rtl/register_write_arbiter_if.sv
// Writeback-side bundle for the register-file write arbiter: two requesters,
// the scrub trigger and the registered write port toward RegisterMemory.
interface register_write_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  reqA;
    logic [ADDR_WIDTH-1:0] addrA;
    logic [DATA_WIDTH-1:0] dataA;
    logic                  grantA;
    logic                  reqB;
    logic [ADDR_WIDTH-1:0] addrB;
    logic [DATA_WIDTH-1:0] dataB;
    logic                  grantB;
    logic                  clearReq;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] rsWrite;
    logic [DATA_WIDTH-1:0] dataWrite;
    logic                  rWrite;

    modport master (
        output reqA, addrA, dataA, reqB, addrB, dataB, clearReq,
        input  grantA, grantB, busy, rsWrite, dataWrite, rWrite
    );

    modport slave (
        input  reqA, addrA, dataA, reqB, addrB, dataB, clearReq,
        output grantA, grantB, busy, rsWrite, dataWrite, rWrite
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// one-register-per-cycle scrub of registers 1..NUM_REGS-1.
module register_write_arbiter #(
    parameter int                    ADDR_WIDTH  = 5,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 32,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    register_write_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
    logic                  last_b, last_b_nx;
    logic [ADDR_WIDTH-1:0] rs_q, rs_nx;
    logic [DATA_WIDTH-1:0] data_q, data_nx;
    logic                  wen_q, wen_nx;
    logic                  grant_a, grant_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            last_b <= 1'b1;
            rs_q   <= '0;
            data_q <= '0;
            wen_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            last_b <= last_b_nx;
            rs_q   <= rs_nx;
            data_q <= data_nx;
            wen_q  <= wen_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        last_b_nx = last_b;
        rs_nx     = rs_q;
        data_nx   = data_q;
        wen_nx    = 1'b0;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.clearReq) begin
                    state_nx = CLEAR;
                    cnt_nx   = FIRST_REG;
                end else begin
                    // Under contention the side that did not win last time goes first.
                    grant_a = !reset && bus.reqA && (!bus.reqB || last_b);
                    grant_b = !reset && bus.reqB && (!bus.reqA || !last_b);
                    if (grant_a) begin
                        rs_nx     = bus.addrA;
                        data_nx   = bus.dataA;
                        wen_nx    = (bus.addrA != '0);
                        last_b_nx = 1'b0;
                    end else if (grant_b) begin
                        rs_nx     = bus.addrB;
                        data_nx   = bus.dataB;
                        wen_nx    = (bus.addrB != '0);
                        last_b_nx = 1'b1;
                    end
                end
            end
            CLEAR: begin
                rs_nx   = cnt;
                data_nx = CLEAR_VALUE;
                wen_nx  = 1'b1;
                if (cnt == LAST_REG) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + FIRST_REG;
                end
            end
        endcase
    end

    assign bus.grantA    = grant_a;
    assign bus.grantB    = grant_b;
    assign bus.busy      = (state == CLEAR);
    assign bus.rsWrite   = rs_q;
    assign bus.dataWrite = data_q;
    assign bus.rWrite    = wen_q;
endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter: directed scenarios plus a randomized run
// against a queue-based behavioural model of arbitration and scrubbing.
module tb_register_write_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    register_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    register_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.reqA = 1'b0; bus.addrA = '0; bus.dataA = '0;
        bus.reqB = 1'b0; bus.addrB = '0; bus.dataB = '0;
        bus.clearReq = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.reqA = 1'b1; bus.addrA = 5'd5; bus.reqB = 1'b1; bus.addrB = 5'd6;
        #1;
        checks++; if (bus.grantA !== 1'b0) begin failures++; $display("FAIL rst_grantA got=%0b exp=0", bus.grantA); end
        checks++; if (bus.grantB !== 1'b0) begin failures++; $display("FAIL rst_grantB got=%0b exp=0", bus.grantB); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        @(posedge clk); #1;
        checks++; if (bus.rWrite !== 1'b0) begin failures++; $display("FAIL rst_rWrite got=%0b exp=0", bus.rWrite); end
        checks++; if (bus.rsWrite !== 5'd0) begin failures++; $display("FAIL rst_rsWrite got=%0h exp=0", bus.rsWrite); end
        checks++; if (bus.dataWrite !== 32'd0) begin failures++; $display("FAIL rst_dataWrite got=%0h exp=0", bus.dataWrite); end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        bus.reqA = 1'b1; bus.addrA = 5'd5; bus.dataA = 32'hA5;
        #1;
        checks++; if (bus.grantA !== 1'b1) begin failures++; $display("FAIL single_grantA got=%0b exp=1", bus.grantA); end
        checks++; if (bus.grantB !== 1'b0) begin failures++; $display("FAIL single_grantB got=%0b exp=0", bus.grantB); end
        @(posedge clk); #1;
        bus.reqA = 1'b0;
        checks++; if (bus.rWrite !== 1'b1) begin failures++; $display("FAIL single_rWrite got=%0b exp=1", bus.rWrite); end
        checks++; if (bus.rsWrite !== 5'd5) begin failures++; $display("FAIL single_rsWrite got=%0h exp=5", bus.rsWrite); end
        checks++; if (bus.dataWrite !== 32'hA5) begin failures++; $display("FAIL single_dataWrite got=%0h exp=a5", bus.dataWrite); end
        @(posedge clk); #1;
        checks++; if (bus.rWrite !== 1'b0) begin failures++; $display("FAIL single_idle_rWrite got=%0b exp=0", bus.rWrite); end
        checks++; if (bus.rsWrite !== 5'd5) begin failures++; $display("FAIL single_hold_rsWrite got=%0h exp=5", bus.rsWrite); end
        idle_inputs();
    endtask

    task automatic test_alternate();
        logic exp_a;
        do_reset();
        bus.reqA = 1'b1; bus.addrA = 5'd3; bus.dataA = 32'h11;
        bus.reqB = 1'b1; bus.addrB = 5'd4; bus.dataB = 32'h22;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            #1;
            checks++; if (bus.grantA !== exp_a) begin failures++; $display("FAIL alt_grantA[%0d] got=%0b exp=%0b", i, bus.grantA, exp_a); end
            checks++; if (bus.grantB !== !exp_a) begin failures++; $display("FAIL alt_grantB[%0d] got=%0b exp=%0b", i, bus.grantB, !exp_a); end
            @(posedge clk); #1;
            checks++; if (bus.rWrite !== 1'b1) begin failures++; $display("FAIL alt_rWrite[%0d] got=%0b exp=1", i, bus.rWrite); end
            checks++; if (bus.rsWrite !== (exp_a ? 5'd3 : 5'd4)) begin failures++; $display("FAIL alt_rsWrite[%0d] got=%0h exp=%0h", i, bus.rsWrite, exp_a ? 5'd3 : 5'd4); end
            checks++; if (bus.dataWrite !== (exp_a ? 32'h11 : 32'h22)) begin failures++; $display("FAIL alt_dataWrite[%0d] got=%0h exp=%0h", i, bus.dataWrite, exp_a ? 32'h11 : 32'h22); end
        end
        idle_inputs();
    endtask

    task automatic test_x0();
        do_reset();
        bus.reqA = 1'b1; bus.addrA = 5'd0; bus.dataA = 32'h77;
        #1;
        checks++; if (bus.grantA !== 1'b1) begin failures++; $display("FAIL x0_grantA got=%0b exp=1", bus.grantA); end
        @(posedge clk); #1;
        checks++; if (bus.rWrite !== 1'b0) begin failures++; $display("FAIL x0_rWrite got=%0b exp=0", bus.rWrite); end
        bus.addrA = 5'd6; bus.dataA = 32'h66;
        bus.reqB = 1'b1; bus.addrB = 5'd9; bus.dataB = 32'h99;
        #1;
        checks++; if (bus.grantB !== 1'b1) begin failures++; $display("FAIL x0_next_grantB got=%0b exp=1", bus.grantB); end
        checks++; if (bus.grantA !== 1'b0) begin failures++; $display("FAIL x0_next_grantA got=%0b exp=0", bus.grantA); end
        @(posedge clk); #1;
        checks++; if (bus.rWrite !== 1'b1) begin failures++; $display("FAIL x0_b_rWrite got=%0b exp=1", bus.rWrite); end
        checks++; if (bus.rsWrite !== 5'd9) begin failures++; $display("FAIL x0_b_rsWrite got=%0h exp=9", bus.rsWrite); end
        idle_inputs();
    endtask

    task automatic test_scrub();
        int busy_cycles = 0;
        do_reset();
        bus.reqA = 1'b1; bus.addrA = 5'd7; bus.dataA = 32'h55;
        bus.clearReq = 1'b1;
        #1;
        checks++; if (bus.grantA !== 1'b0) begin failures++; $display("FAIL scrub_start_grantA got=%0b exp=0", bus.grantA); end
        @(posedge clk); #1;
        bus.clearReq = 1'b0;
        checks++; if (bus.rWrite !== 1'b0) begin failures++; $display("FAIL scrub_e0_rWrite got=%0b exp=0", bus.rWrite); end
        for (int k = 1; k < NR; k++) begin
            #1;
            checks++; if (bus.grantA !== 1'b0) begin failures++; $display("FAIL scrub_grantA[%0d] got=%0b exp=0", k, bus.grantA); end
            if (bus.busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            checks++; if (bus.rWrite !== 1'b1) begin failures++; $display("FAIL scrub_rWrite[%0d] got=%0b exp=1", k, bus.rWrite); end
            checks++; if (bus.rsWrite !== AW'(k)) begin failures++; $display("FAIL scrub_rsWrite[%0d] got=%0h exp=%0h", k, bus.rsWrite, k); end
            checks++; if (bus.dataWrite !== 32'd0) begin failures++; $display("FAIL scrub_dataWrite[%0d] got=%0h exp=0", k, bus.dataWrite); end
        end
        checks++; if (busy_cycles != NR - 1) begin failures++; $display("FAIL scrub_busy_cycles got=%0d exp=%0d", busy_cycles, NR - 1); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL scrub_end_busy got=%0b exp=0", bus.busy); end
        #1;
        checks++; if (bus.grantA !== 1'b1) begin failures++; $display("FAIL scrub_after_grantA got=%0b exp=1", bus.grantA); end
        @(posedge clk); #1;
        checks++; if (bus.rsWrite !== 5'd7 || bus.rWrite !== 1'b1) begin failures++; $display("FAIL scrub_after_write got=%0h/%0b exp=7/1", bus.rsWrite, bus.rWrite); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_scrub();
        int stray = 0;
        do_reset();
        bus.clearReq = 1'b1;
        @(posedge clk); #1;
        bus.clearReq = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        checks++; if (bus.rsWrite !== 5'd9) begin failures++; $display("FAIL mid_pre_rsWrite got=%0h exp=9", bus.rsWrite); end
        reset = 1'b1;
        #1;
        checks++; if (bus.rWrite !== 1'b0) begin failures++; $display("FAIL mid_rWrite got=%0b exp=0", bus.rWrite); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.rsWrite !== 5'd0) begin failures++; $display("FAIL mid_rsWrite got=%0h exp=0", bus.rsWrite); end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.reqA = 1'b1; bus.addrA = 5'd2; bus.dataA = 32'h2;
        bus.reqB = 1'b1; bus.addrB = 5'd3; bus.dataB = 32'h3;
        #1;
        checks++; if (bus.grantA !== 1'b1 || bus.grantB !== 1'b0) begin failures++; $display("FAIL mid_after_grants got=%0b%0b exp=10", bus.grantA, bus.grantB); end
        @(posedge clk); #1;
        idle_inputs();
        checks++; if (bus.rsWrite !== 5'd2) begin failures++; $display("FAIL mid_after_rsWrite got=%0h exp=2", bus.rsWrite); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.rWrite !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL mid_no_resume got=%0d exp=0", stray); end
    endtask

    task automatic test_clear_with_req();
        int writes = 0;
        int cycles = 0;
        int seq_bad = 0;
        int grant_bad = 0;
        logic [AW-1:0] exp_reg = 5'd1;
        do_reset();
        bus.clearReq = 1'b1;
        bus.reqB = 1'b1; bus.addrB = 5'd12; bus.dataB = 32'hCC;
        #1;
        checks++; if (bus.grantB !== 1'b0) begin failures++; $display("FAIL cr_grantB got=%0b exp=0", bus.grantB); end
        @(posedge clk); #1;
        bus.clearReq = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL cr_busy got=%0b exp=1", bus.busy); end
        while (bus.busy === 1'b1 && cycles < 100) begin
            bus.clearReq = (cycles == 15);
            #1;
            if (bus.grantB !== 1'b0) grant_bad++;
            @(posedge clk); #1;
            if (bus.rWrite === 1'b1) begin
                if (bus.rsWrite !== exp_reg) seq_bad++;
                exp_reg++;
                writes++;
            end
            cycles++;
        end
        bus.clearReq = 1'b0;
        checks++; if (cycles >= 100) begin failures++; $display("FAIL cr_timeout got=%0d exp=<100", cycles); end
        checks++; if (writes != NR - 1) begin failures++; $display("FAIL cr_writes got=%0d exp=%0d", writes, NR - 1); end
        checks++; if (seq_bad != 0) begin failures++; $display("FAIL cr_sequence got=%0d exp=0", seq_bad); end
        checks++; if (grant_bad != 0) begin failures++; $display("FAIL cr_grant_during got=%0d exp=0", grant_bad); end
        #1;
        checks++; if (bus.grantB !== 1'b1) begin failures++; $display("FAIL cr_after_grantB got=%0b exp=1", bus.grantB); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_random();
        logic          m_last_b = 1'b1;
        logic [AW-1:0] scrub_q[$];
        logic [AW-1:0] exp_rs = '0;
        logic [DW-1:0] exp_data = '0;
        logic          exp_wen = 1'b0;
        logic          ea, eb;
        logic          a_hold = 1'b0, b_hold = 1'b0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (!a_hold) begin
                bus.reqA  = 1'($urandom_range(0, 1));
                bus.addrA = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
                bus.dataA = $urandom;
            end
            if (!b_hold) begin
                bus.reqB  = 1'($urandom_range(0, 1));
                bus.addrB = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
                bus.dataB = $urandom;
            end
            bus.clearReq = ($urandom_range(0, 29) == 0);
            #1;
            ea = 1'b0; eb = 1'b0;
            if (scrub_q.size() == 0 && !bus.clearReq) begin
                if (bus.reqA && bus.reqB) begin
                    ea = m_last_b; eb = !m_last_b;
                end else begin
                    ea = bus.reqA; eb = bus.reqB;
                end
            end
            checks++; if (bus.grantA !== ea) begin failures++; $display("FAIL rnd_grantA[%0d] got=%0b exp=%0b", n, bus.grantA, ea); end
            checks++; if (bus.grantB !== eb) begin failures++; $display("FAIL rnd_grantB[%0d] got=%0b exp=%0b", n, bus.grantB, eb); end
            exp_wen = 1'b0;
            if (scrub_q.size() != 0) begin
                exp_rs = scrub_q.pop_front(); exp_data = '0; exp_wen = 1'b1;
            end else if (bus.clearReq) begin
                for (int r = 1; r < NR; r++) scrub_q.push_back(AW'(r));
            end else if (ea) begin
                exp_rs = bus.addrA; exp_data = bus.dataA; exp_wen = (bus.addrA != 0); m_last_b = 1'b0;
            end else if (eb) begin
                exp_rs = bus.addrB; exp_data = bus.dataB; exp_wen = (bus.addrB != 0); m_last_b = 1'b1;
            end
            a_hold = bus.reqA && !ea;
            b_hold = bus.reqB && !eb;
            @(posedge clk); #1;
            checks++; if (bus.rWrite !== exp_wen) begin failures++; $display("FAIL rnd_rWrite[%0d] got=%0b exp=%0b", n, bus.rWrite, exp_wen); end
            checks++; if (bus.rsWrite !== exp_rs) begin failures++; $display("FAIL rnd_rsWrite[%0d] got=%0h exp=%0h", n, bus.rsWrite, exp_rs); end
            checks++; if (bus.dataWrite !== exp_data) begin failures++; $display("FAIL rnd_dataWrite[%0d] got=%0h exp=%0h", n, bus.dataWrite, exp_data); end
            checks++; if (bus.busy !== (scrub_q.size() != 0)) begin failures++; $display("FAIL rnd_busy[%0d] got=%0b exp=%0b", n, bus.busy, scrub_q.size() != 0); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_alternate();
        test_x0();
        test_scrub();
        test_reset_mid_scrub();
        test_clear_with_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
